booth_divider_module: RTL

Sequential signed integer divider, the inverse operation of the team's Booth multiplier. It computes quotient and remainder of two WIDTH-bit two's-complement operands using a start/done handshake. It is a radix-2 restoring algorithm on operand magnitudes, one iteration per clock, followed by a sign fix-up. It sits beside the multiplier in the arithmetic test designs and is driven by the same control FSMs.

---
 rtl/arith_pkg.sv | 14 +
 rtl/booth_divider_module_if.sv | 28 ++
 rtl/booth_divider_module.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the Booth multiplier / divider pair.
// Holds the divider state encoding and the default operand width.
package arith_pkg;

    localparam int ARITH_W = 8;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_ITER = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/booth_divider_module_if.sv
// Start/done handshake, operand and result bundle for the signed divider.
// The master side issues requests; the slave side is the divider itself.
interface booth_divider_module_if #(
    parameter int WIDTH = 8
) ();

    logic             start_sig;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done_sig;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;
    logic [WIDTH:0]   SQ_r;
    logic [WIDTH-1:0] SQ_q;

    modport master (
        output start_sig, dividend, divisor,
        input  busy, done_sig, quotient, remainder, div_zero, SQ_r, SQ_q
    );

    modport slave (
        input  start_sig, dividend, divisor,
        output busy, done_sig, quotient, remainder, div_zero, SQ_r, SQ_q
    );

endinterface

// File: rtl/booth_divider_module.sv
// Sequential signed divider: radix-2 restoring division on operand magnitudes,
// one iteration per clock, followed by a one-cycle sign fix-up.
module booth_divider_module
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    booth_divider_module_if.slave  div_if
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_mag_q, dvs_mag_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic             sd_q, sd_d;
    logic             sv_q, sv_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_zero_q, div_zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        r_d         = r_q;
        q_d         = q_q;
        dvs_mag_d   = dvs_mag_q;
        dvd_d       = dvd_q;
        sd_d        = sd_q;
        sv_d        = sv_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;

        shifted = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_mag_q};

        case (state_q)
            DIV_IDLE: begin
                if (div_if.start_sig) begin
                    sd_d      = div_if.dividend[WIDTH-1];
                    sv_d      = div_if.divisor[WIDTH-1];
                    dvd_d     = div_if.dividend;
                    // The most-negative value negates to itself, which read unsigned is 2^(WIDTH-1).
                    dvs_mag_d = div_if.divisor[WIDTH-1]  ? -div_if.divisor  : div_if.divisor;
                    q_d       = div_if.dividend[WIDTH-1] ? -div_if.dividend : div_if.dividend;
                    r_d       = '0;
                    count_d   = '0;
                    state_d   = DIV_ITER;
                end
            end
            DIV_ITER: begin
                if (!trial[WIDTH]) begin
                    r_d = trial;
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_d = shifted;
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = DIV_FIX;
                end
            end
            DIV_FIX: begin
                // A zero divisor ran the iterations anyway so latency stays constant; discard them.
                if (dvs_mag_q == '0) begin
                    quotient_d  = '1;
                    remainder_d = dvd_q;
                    div_zero_d  = 1'b1;
                end else begin
                    quotient_d  = (sd_q ^ sv_q) ? -q_q : q_q;
                    remainder_d = sd_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
                    div_zero_d  = 1'b0;
                end
                state_d = DIV_DONE;
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase

        busy_d = (state_d != DIV_IDLE);
        done_d = (state_d == DIV_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= DIV_IDLE;
            count_q     <= '0;
            r_q         <= '0;
            q_q         <= '0;
            dvs_mag_q   <= '0;
            dvd_q       <= '0;
            sd_q        <= 1'b0;
            sv_q        <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            r_q         <= r_d;
            q_q         <= q_d;
            dvs_mag_q   <= dvs_mag_d;
            dvd_q       <= dvd_d;
            sd_q        <= sd_d;
            sv_q        <= sv_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign div_if.busy      = busy_q;
    assign div_if.done_sig  = done_q;
    assign div_if.quotient  = quotient_q;
    assign div_if.remainder = remainder_q;
    assign div_if.div_zero  = div_zero_q;
    assign div_if.SQ_r      = r_q;
    assign div_if.SQ_q      = q_q;

endmodule
